// File: rtl/aes_out_stream_pkg.sv
// Shared definitions for the AES output streamer: data widths, FSM state
// encoding and a small word-position helper.
package aes_out_stream_pkg;

    localparam int BYTE_S        = 8;
    localparam int WORD_S        = 32;
    localparam int BLK_S         = 128;
    localparam int WORDS_PER_BLK = BLK_S / WORD_S;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    // True when the word index points at the least-significant (final) word
    // of a 128-bit block.
    function automatic logic word_is_last(input logic [1:0] word_idx);
        return (word_idx == 2'd3);
    endfunction

endpackage

// File: rtl/aes_blk_serializer.sv
// 128->32 serializer: loads one block, presents the most-significant word
// first and shifts on every stream handshake. Produces a registered last-beat
// flag for the final word of the final block.
module aes_blk_serializer
    import aes_out_stream_pkg::*;
#(
    parameter int BLK_W  = BLK_S,
    parameter int WORD_W = WORD_S
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BLK_W-1:0]  data,
    input  logic              ready,
    input  logic              last_blk,
    output logic              valid,
    output logic [WORD_W-1:0] word,
    output logic              last,
    output logic [1:0]        word_idx,
    output logic              handshake_last
);

    logic [BLK_W-1:0] shift_r;
    logic [1:0]       word_idx_r;
    logic             valid_r;
    logic             last_r;

    // Shift register, word counter, valid and last flags; all hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r    <= {BLK_W{1'b0}};
            word_idx_r <= 2'd0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
        end else if (load) begin
            shift_r    <= data;
            word_idx_r <= 2'd0;
            valid_r    <= 1'b1;
            last_r     <= 1'b0;
        end else if (valid_r && ready) begin
            shift_r    <= shift_r << WORD_W;
            word_idx_r <= word_idx_r + 2'd1;
            valid_r    <= !word_is_last(word_idx_r);
            // Next word is word 3: it carries TLAST only in the final block.
            last_r     <= (word_idx_r == 2'd2) && last_blk;
        end
    end

    assign valid          = valid_r;
    assign word           = shift_r[BLK_W-1 -: WORD_W];
    assign last           = last_r;
    assign word_idx       = word_idx_r;
    assign handshake_last = valid_r && ready && word_is_last(word_idx_r);

endmodule

// File: rtl/aes_out_stream.sv
// Drains the AES output block RAM into an AXI4-Stream master as 32-bit beats,
// most-significant word first, with TLAST on the final beat of the final block.
module aes_out_stream
    import aes_out_stream_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH      = 9,
    parameter int FIFO_DATA_WIDTH      = BLK_S,
    parameter int C_M_AXIS_TDATA_WIDTH = WORD_S
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [FIFO_ADDR_WIDTH-1:0]      blk_cnt,
    output logic                            fifo_r_e,
    output logic [FIFO_ADDR_WIDTH-1:0]      fifo_addr,
    input  logic [0:FIFO_DATA_WIDTH-1]      fifo_data,
    output logic                            m_axis_tvalid,
    output logic [0:C_M_AXIS_TDATA_WIDTH-1] m_axis_tdata,
    output logic [3:0]                      m_axis_tstrb,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            busy,
    output logic                            done
);

    localparam logic [FIFO_ADDR_WIDTH-1:0] ADDR_ONE  = FIFO_ADDR_WIDTH'(1'b1);
    localparam logic [FIFO_ADDR_WIDTH-1:0] ADDR_ZERO = {FIFO_ADDR_WIDTH{1'b0}};

    state_e                     state_r;
    state_e                     state_next;
    logic [FIFO_ADDR_WIDTH-1:0] blk_idx_r;
    logic [FIFO_ADDR_WIDTH-1:0] blk_idx_next;
    logic [FIFO_ADDR_WIDTH-1:0] cnt_q_r;
    logic [FIFO_ADDR_WIDTH-1:0] cnt_q_next;
    logic                       fifo_r_e_r;
    logic [FIFO_ADDR_WIDTH-1:0] fifo_addr_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       done_next;
    logic                       load_s;
    logic                       last_blk_s;
    logic                       hs_last_s;
    logic                       ser_valid_s;
    logic                       ser_last_s;
    logic [WORD_S-1:0]          ser_word_s;
    logic [1:0]                 ser_word_idx_s;

    // cnt_q is at least 1 whenever this is used, so the subtraction never wraps.
    assign last_blk_s = (blk_idx_r == (cnt_q_r - ADDR_ONE));

    aes_blk_serializer #(
        .BLK_W  (FIFO_DATA_WIDTH),
        .WORD_W (C_M_AXIS_TDATA_WIDTH)
    ) u_ser (
        .clk            (clk),
        .reset          (reset),
        .load           (load_s),
        .data           (fifo_data),
        .ready          (m_axis_tready),
        .last_blk       (last_blk_s),
        .valid          (ser_valid_s),
        .word           (ser_word_s),
        .last           (ser_last_s),
        .word_idx       (ser_word_idx_s),
        .handshake_last (hs_last_s)
    );

    // Next-state, block counter and strobe decode for the transfer FSM.
    always_comb begin
        state_next   = state_r;
        blk_idx_next = blk_idx_r;
        cnt_q_next   = cnt_q_r;
        done_next    = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (blk_cnt == ADDR_ZERO) begin
                        done_next = 1'b1;
                    end else begin
                        cnt_q_next   = blk_cnt;
                        blk_idx_next = ADDR_ZERO;
                        state_next   = ST_RD;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                load_s     = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (hs_last_s) begin
                    if (last_blk_s) begin
                        state_next = ST_FIN;
                    end else begin
                        blk_idx_next = blk_idx_r + ADDR_ONE;
                        state_next   = ST_RD;
                    end
                end else begin
                    state_next = ST_SEND;
                end
            end
            ST_FIN: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered RAM/status outputs (decoded from next state
    // so they line up with the state they belong to).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            blk_idx_r   <= ADDR_ZERO;
            cnt_q_r     <= ADDR_ZERO;
            fifo_r_e_r  <= 1'b0;
            fifo_addr_r <= ADDR_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r    <= state_next;
            blk_idx_r  <= blk_idx_next;
            cnt_q_r    <= cnt_q_next;
            fifo_r_e_r <= (state_next == ST_RD);
            if (state_next == ST_RD) begin
                fifo_addr_r <= blk_idx_next;
            end
            busy_r     <= (state_next != ST_IDLE);
            done_r     <= done_next;
        end
    end

    assign fifo_r_e      = fifo_r_e_r;
    assign fifo_addr     = fifo_addr_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign m_axis_tvalid = ser_valid_s;
    assign m_axis_tdata  = ser_word_s;
    assign m_axis_tlast  = ser_last_s;
    assign m_axis_tstrb  = 4'hF;

endmodule
